voice_mixer_mac: RTL and testbench

Time-multiplexed weighted voice mixer; successor to the combinational-tree mixer between the voice bank and the effects chain. Accepts one frame of NUM_VOICES signed samples with per-voice gain and enable mask, sums LANES products per cycle into a wide accumulator, and normalises and saturates the result. It drives a valid/ready output held under backpressure. Adds gain, masking, selectable normalisation and a clip flag, at reduced multiplier count.

---
 rtl/voice_mixer_mac.sv | 194 +++++++++++++++++++
 tb/tb_voice_mixer_mac.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_mixer_mac.sv
// voice_mixer_mac
//   Time-multiplexed weighted voice mixer. Accepts one frame of NUM_VOICES
//   signed samples with per-voice unsigned Q1.(GAIN_WIDTH-1) gains and an
//   enable mask. Accumulates LANES gained products per cycle into a wide
//   accumulator, then normalises, saturates and presents the result on a
//   valid/ready output that is held under backpressure.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   voice_in_flat   voice i at [i*DATA_WIDTH +: DATA_WIDTH], signed
//   gain_flat       gain i at [i*GAIN_WIDTH +: GAIN_WIDTH], unsigned Q1.x
//   voice_mask      bit i = 1 includes voice i in the mix
//   norm_mode       0/3: shift by log2(NUM_VOICES); 1: ceil(log2(active));
//                   2: no shift
//   data_in_valid   frame present
//   data_in_ready   mixer can accept a frame (registered)
//   mixed_out       normalised, saturated mix (registered)
//   data_out_valid  mixed_out/clip valid (registered)
//   data_out_ready  downstream accepts
//   clip            current output was saturated (registered)
module voice_mixer_mac #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_VOICES = 16,
  parameter int LANES      = 4,
  parameter int GAIN_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_WIDTH*NUM_VOICES-1:0] voice_in_flat,
  input  logic [GAIN_WIDTH*NUM_VOICES-1:0] gain_flat,
  input  logic [NUM_VOICES-1:0]            voice_mask,
  input  logic [1:0]                       norm_mode,
  input  logic                             data_in_valid,
  output logic                             data_in_ready,
  output logic [DATA_WIDTH-1:0]            mixed_out,
  output logic                             data_out_valid,
  input  logic                             data_out_ready,
  output logic                             clip
);

  localparam int BEATS      = NUM_VOICES / LANES;
  localparam int ACC_W      = DATA_WIDTH + 2 + $clog2(NUM_VOICES);
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int VIDX_W     = $clog2(NUM_VOICES);
  localparam int CNT_W      = $clog2(NUM_VOICES) + 1;
  localparam int PROD_W     = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam int FULL_SHIFT = $clog2(NUM_VOICES);
  localparam int SH_W       = $clog2(FULL_SHIFT + 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_NORM,
    S_OUT
  } state_t;

  state_t                         state;
  logic signed [DATA_WIDTH-1:0]   voice_r [NUM_VOICES];
  logic        [GAIN_WIDTH-1:0]   gain_r  [NUM_VOICES];
  logic        [NUM_VOICES-1:0]   mask_r;
  logic        [1:0]              mode_r;
  logic signed [ACC_W-1:0]        acc_r;
  logic        [CNT_W-1:0]        cnt_r;
  logic        [BEAT_W-1:0]       beat_r;

  logic        [VIDX_W-1:0]       vidx;
  logic signed [PROD_W-1:0]       prod;
  logic signed [ACC_W-1:0]        lane_sum;
  logic        [CNT_W-1:0]        lane_cnt;

  logic        [SH_W-1:0]         shamt;
  logic signed [ACC_W-1:0]        acc_sh;
  logic signed [DATA_WIDTH-1:0]   norm_out;
  logic                           norm_clip;

  // Smallest s with 2^s >= n (n >= 1); 0 for n <= 1.
  function automatic logic [SH_W-1:0] ceil_log2(input logic [CNT_W-1:0] n);
    logic [SH_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < FULL_SHIFT; i++) begin
      if ((CNT_W'(1) << i) < n) r = SH_W'(i + 1);
    end
    return r;
  endfunction

  // Gained products for the voices of the current beat. The gain is
  // zero-extended so the multiply stays signed; >>> gives floor rounding.
  always_comb begin
    lane_sum = '0;
    lane_cnt = '0;
    vidx     = '0;
    prod     = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      vidx = VIDX_W'(32'(beat_r) * LANES + l);
      prod = $signed(voice_r[vidx]) * $signed({1'b0, gain_r[vidx]});
      if (mask_r[vidx]) begin
        lane_sum = lane_sum + ACC_W'(prod >>> (GAIN_WIDTH - 1));
        lane_cnt = lane_cnt + CNT_W'(1);
      end
    end
  end

  // Normalisation shift and saturation of the finished accumulator.
  always_comb begin
    shamt = SH_W'(FULL_SHIFT);
    case (mode_r)
      2'd1:    shamt = ceil_log2(cnt_r);
      2'd2:    shamt = '0;
      default: shamt = SH_W'(FULL_SHIFT);
    endcase
    acc_sh    = acc_r >>> shamt;
    norm_out  = acc_sh[DATA_WIDTH-1:0];
    norm_clip = 1'b0;
    if (mode_r == 2'd1 && cnt_r == '0) begin
      norm_out = '0;
    end else if (acc_sh > SAT_MAX) begin
      norm_out  = SAT_MAX[DATA_WIDTH-1:0];
      norm_clip = 1'b1;
    end else if (acc_sh < SAT_MIN) begin
      norm_out  = SAT_MIN[DATA_WIDTH-1:0];
      norm_clip = 1'b1;
    end
  end

  // data_in_ready is a register so it stays low through reset and rises on
  // the first edge spent in IDLE; an accept needs it already high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      data_in_ready  <= 1'b0;
      data_out_valid <= 1'b0;
      mixed_out      <= '0;
      clip           <= 1'b0;
      mask_r         <= '0;
      mode_r         <= '0;
      acc_r          <= '0;
      cnt_r          <= '0;
      beat_r         <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        voice_r[i] <= '0;
        gain_r[i]  <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          data_in_ready <= 1'b1;
          if (data_in_ready && data_in_valid) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
              voice_r[i] <= voice_in_flat[i*DATA_WIDTH +: DATA_WIDTH];
              gain_r[i]  <= gain_flat[i*GAIN_WIDTH +: GAIN_WIDTH];
            end
            mask_r        <= voice_mask;
            mode_r        <= norm_mode;
            acc_r         <= '0;
            cnt_r         <= '0;
            beat_r        <= '0;
            data_in_ready <= 1'b0;
            state         <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc_r <= acc_r + lane_sum;
          cnt_r <= cnt_r + lane_cnt;
          if (beat_r == BEAT_W'(BEATS - 1)) begin
            state <= S_NORM;
          end else begin
            beat_r <= beat_r + BEAT_W'(1);
          end
        end
        S_NORM: begin
          mixed_out      <= norm_out;
          clip           <= norm_clip;
          data_out_valid <= 1'b1;
          state          <= S_OUT;
        end
        S_OUT: begin
          if (data_out_ready) begin
            data_out_valid <= 1'b0;
            data_in_ready  <= 1'b1;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mixer_mac.sv
// tb_voice_mixer_mac
//   Self-checking bench for voice_mixer_mac with default parameters:
//   directed vector table, randomized frames against a behavioural model,
//   and hand-written backpressure and mid-frame reset sequences.
module tb_voice_mixer_mac;

  localparam int DW = 32;
  localparam int NV = 16;
  localparam int GW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [DW*NV-1:0]     voice_in_flat;
  logic [GW*NV-1:0]     gain_flat;
  logic [NV-1:0]        voice_mask;
  logic [1:0]           norm_mode;
  logic                 data_in_valid;
  logic                 data_in_ready;
  logic [DW-1:0]        mixed_out;
  logic                 data_out_valid;
  logic                 data_out_ready;
  logic                 clip;

  int tests  = 0;
  int failed = 0;

  voice_mixer_mac #(
    .DATA_WIDTH(DW),
    .NUM_VOICES(NV),
    .LANES(4),
    .GAIN_WIDTH(GW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .voice_in_flat(voice_in_flat),
    .gain_flat(gain_flat),
    .voice_mask(voice_mask),
    .norm_mode(norm_mode),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .mixed_out(mixed_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .clip(clip)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW*NV-1:0] vf;
    logic [GW*NV-1:0] gf;
    logic [NV-1:0]    mask;
    logic [1:0]       mode;
    logic [DW-1:0]    exp_out;
    logic             exp_clip;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [DW*NV-1:0] rep_v(input logic [DW-1:0] x);
    logic [DW*NV-1:0] r;
    for (int i = 0; i < NV; i++) r[i*DW +: DW] = x;
    return r;
  endfunction

  function automatic logic [GW*NV-1:0] rep_g(input logic [GW-1:0] x);
    logic [GW*NV-1:0] r;
    for (int i = 0; i < NV; i++) r[i*GW +: GW] = x;
    return r;
  endfunction

  // Behavioural reference: plain 64-bit arithmetic on the mixing rules.
  task automatic model(input logic [DW*NV-1:0] vf, input logic [GW*NV-1:0] gf,
                       input logic [NV-1:0] m, input logic [1:0] md,
                       output logic [DW-1:0] o, output logic c);
    longint sum = 0;
    longint r;
    int     cnt = 0;
    int     sh;
    for (int i = 0; i < NV; i++) begin
      if (m[i]) begin
        longint v = longint'($signed(vf[i*DW +: DW]));
        longint g = longint'({1'b0, gf[i*GW +: GW]});
        sum += (v * g) >>> (GW - 1);
        cnt++;
      end
    end
    o = '0;
    c = 1'b0;
    if (md == 2'd1 && cnt == 0) return;
    if (md == 2'd2) sh = 0;
    else if (md == 2'd1) begin
      sh = 0;
      while ((1 << sh) < cnt) sh++;
    end else sh = 4;
    r = sum >>> sh;
    if (r > 64'sd2147483647) begin
      o = 32'h7FFFFFFF; c = 1'b1;
    end else if (r < -64'sd2147483648) begin
      o = 32'h80000000; c = 1'b1;
    end else begin
      o = r[31:0];
    end
  endtask

  task automatic start_frame(input logic [DW*NV-1:0] vf, input logic [GW*NV-1:0] gf,
                             input logic [NV-1:0] m, input logic [1:0] md);
    int k = 0;
    while (!data_in_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if (!data_in_ready) begin
      tests++; failed++;
      $display("FAIL accept_wait: got ready=0 expected ready=1 within 50 cycles");
    end
    voice_in_flat = vf;
    gain_flat     = gf;
    voice_mask    = m;
    norm_mode     = md;
    data_in_valid = 1'b1;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit ready_seen);
    lat = 0;
    ready_seen = 1'b0;
    while (!data_out_valid && lat < 50) begin
      if (data_in_ready) ready_seen = 1'b1;
      @(posedge clk); #1; lat++;
    end
    if (data_in_ready) ready_seen = 1'b1;
    if (!data_out_valid) begin
      tests++; failed++;
      $display("FAIL valid_wait: got valid=0 expected valid=1 within 50 cycles");
    end
  endtask

  task automatic run_check(input string nm, input logic [DW*NV-1:0] vf,
                           input logic [GW*NV-1:0] gf, input logic [NV-1:0] m,
                           input logic [1:0] md, input logic [DW-1:0] eo, input logic ec);
    int lat;
    bit rs;
    start_frame(vf, gf, m, md);
    wait_valid(lat, rs);
    check({nm, "_out"}, mixed_out, eo);
    check({nm, "_clip"}, {31'b0, clip}, {31'b0, ec});
    check({nm, "_latency"}, lat, 5);
    check({nm, "_ready_low"}, {31'b0, rs}, 0);
  endtask

  // data_in_ready and data_out_valid must never overlap.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && data_in_ready && data_out_valid)
      check("ready_valid_excl", 1, 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within 1 ms");
    $fatal(1);
  end

  initial begin
    vec_t             vecs[$];
    logic [DW*NV-1:0] vf;
    logic [GW*NV-1:0] gf;
    logic [DW-1:0]    eo;
    logic             ec;
    logic [NV-1:0]    m;
    logic [1:0]       md;
    int               lat;
    bit               rs;

    rst_n = 1'b0;
    voice_in_flat = '0;
    gain_flat = '0;
    voice_mask = '0;
    norm_mode = '0;
    data_in_valid = 1'b0;
    data_out_ready = 1'b1;

    // Reset state, release between edges.
    #12;
    check("rst_in_ready", {31'b0, data_in_ready}, 0);
    check("rst_out_valid", {31'b0, data_out_valid}, 0);
    check("rst_mixed_out", mixed_out, 0);
    check("rst_clip", {31'b0, clip}, 0);
    #11 rst_n = 1'b1;
    #1 check("rel_ready_before_edge", {31'b0, data_in_ready}, 0);
    @(posedge clk); #1;
    check("rel_ready_after_edge", {31'b0, data_in_ready}, 1);

    // Directed vectors.
    vecs.push_back('{rep_v(32'd1000), rep_g(16'h8000), 16'hFFFF, 2'd0, 32'd1000, 1'b0});
    vecs.push_back('{rep_v(32'h7FFFFFFF), rep_g(16'h8000), 16'hFFFF, 2'd2, 32'h7FFFFFFF, 1'b1});
    vecs.push_back('{rep_v(32'h80000000), rep_g(16'h8000), 16'hFFFF, 2'd2, 32'h80000000, 1'b1});
    vf = rep_v(32'd99999);
    vf[31:0] = 32'd4096;
    vf[63:32] = -32'sd4096;
    gf = rep_g(16'h8000);
    gf[15:0] = 16'h4000;
    gf[31:16] = 16'hFFFF;
    vecs.push_back('{vf, gf, 16'h0003, 2'd1, -32'sd3072, 1'b0});
    vf = rep_v(32'd99999);
    vf[31:0] = 32'd400;
    vf[63:32] = 32'd400;
    vf[95:64] = 32'd400;
    vecs.push_back('{vf, rep_g(16'h8000), 16'h0007, 2'd1, 32'd300, 1'b0});
    vecs.push_back('{rep_v(32'd99999), rep_g(16'h8000), 16'h0000, 2'd1, 32'd0, 1'b0});
    vecs.push_back('{rep_v(32'd99999), rep_g(16'h8000), 16'h0000, 2'd0, 32'd0, 1'b0});
    for (int i = 0; i < NV; i++) vf[i*DW +: DW] = 32'(i * 100);
    vecs.push_back('{vf, rep_g(16'h8000), 16'hFFFF, 2'd3, 32'd750, 1'b0});
    vecs.push_back('{rep_v(32'd10), rep_g(16'h8000), 16'h00FF, 2'd2, 32'd80, 1'b0});
    vecs.push_back('{rep_v(-32'sd7), rep_g(16'h8000), 16'h0001, 2'd1, -32'sd7, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].vf, vecs[i].gf, vecs[i].mask,
                vecs[i].mode, vecs[i].exp_out, vecs[i].exp_clip);
    end

    // Randomized frames with random output stalls.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NV; i++) begin
        case ($urandom_range(0, 2))
          0: vf[i*DW +: DW] = $urandom;
          1: vf[i*DW +: DW] = 32'($urandom_range(0, 4000)) - 32'd2000;
          default: vf[i*DW +: DW] = ($urandom_range(0, 1) == 0) ? 32'h7FFFFFFF : 32'h80000000;
        endcase
        gf[i*GW +: GW] = 16'($urandom_range(0, 65535));
      end
      m  = ($urandom_range(0, 7) == 0) ? '0 : NV'($urandom);
      md = 2'($urandom_range(0, 3));
      model(vf, gf, m, md, eo, ec);
      start_frame(vf, gf, m, md);
      data_out_ready = ($urandom_range(0, 1) == 0);
      wait_valid(lat, rs);
      for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
        @(posedge clk); #1;
      end
      check($sformatf("rnd%0d_out", n), mixed_out, eo);
      check($sformatf("rnd%0d_clip", n), {31'b0, clip}, {31'b0, ec});
      check($sformatf("rnd%0d_latency", n), lat, 5);
      data_out_ready = 1'b1;
    end

    // Backpressure: output held, inputs ignored while stalled.
    start_frame(rep_v(32'd1000), rep_g(16'h8000), 16'hFFFF, 2'd0);
    data_out_ready = 1'b0;
    wait_valid(lat, rs);
    check("bp_first_out", mixed_out, 32'd1000);
    for (int c = 0; c < 10; c++) begin
      data_in_valid = c[0];
      for (int i = 0; i < NV; i++) voice_in_flat[i*DW +: DW] = $urandom;
      norm_mode = 2'd2;
      @(posedge clk); #1;
      check($sformatf("bp%0d_valid", c), {31'b0, data_out_valid}, 1);
      check($sformatf("bp%0d_out", c), mixed_out, 32'd1000);
      check($sformatf("bp%0d_clip", c), {31'b0, clip}, 0);
      check($sformatf("bp%0d_in_ready", c), {31'b0, data_in_ready}, 0);
    end
    data_in_valid = 1'b0;
    data_out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", {31'b0, data_in_ready}, 1);
    check("bp_release_valid", {31'b0, data_out_valid}, 0);
    run_check("bp_fresh", rep_v(32'd2000), rep_g(16'h8000), 16'hFFFF, 2'd0, 32'd2000, 1'b0);

    // Reset during the second accumulation beat, off the clock edge.
    start_frame(rep_v(32'd5000), rep_g(16'h8000), 16'hFFFF, 2'd0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'b0, data_in_ready}, 0);
    check("mid_rst_valid", {31'b0, data_out_valid}, 0);
    check("mid_rst_out", mixed_out, 0);
    check("mid_rst_clip", {31'b0, clip}, 0);
    #10 rst_n = 1'b1;
    #1 check("mid_rel_ready_before_edge", {31'b0, data_in_ready}, 0);
    @(posedge clk); #1;
    check("mid_rel_ready_after_edge", {31'b0, data_in_ready}, 1);
    check("mid_rel_valid", {31'b0, data_out_valid}, 0);
    run_check("post_rst", rep_v(32'd1000), rep_g(16'h8000), 16'hFFFF, 2'd0, 32'd1000, 1'b0);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
